pc_sequencer: RTL

Instruction-cycle sequencer for the 4-bit CPU core. Generates the 8-step instruction cycle (A1–A3, M1–M2, X1–X3) and latches the fetched opcode nibbles. Decodes jump/call/return opcodes into the program-counter stack's `cycle`, `control`, `pc_write_enable`, `pc_next_sel` and `halt` inputs. Also owns the external halt handshake and tracks call depth.

---
 rtl/pc_sequencer_pkg.sv | 40 ++++
 rtl/pc_sequencer_cycle_counter.sv | 22 ++
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the instruction-cycle sequencer: stack controls, PC source
// selects, opcode constants and the names of the eight cycle steps.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        STK_NOP  = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2
    } stack_ctl_e;

    typedef enum logic [1:0] {
        SEL_DATA = 2'd0,
        SEL_REG  = 2'd1,
        SEL_INST = 2'd2
    } next_sel_e;

    localparam logic [3:0] OP_JCN = 4'h1;
    localparam logic [3:0] OP_FIM = 4'h2;
    localparam logic [3:0] OP_JIN = 4'h3;
    localparam logic [3:0] OP_JUN = 4'h4;
    localparam logic [3:0] OP_JMS = 4'h5;
    localparam logic [3:0] OP_ISZ = 4'h7;
    localparam logic [3:0] OP_BBL = 4'hC;

    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    // FIM with an odd OPA is SRC, which is single-word.
    function automatic logic is_two_word(input logic [3:0] op_r, input logic [3:0] op_a);
        return (op_r == OP_JCN) || (op_r == OP_JUN) || (op_r == OP_JMS) ||
               (op_r == OP_ISZ) || ((op_r == OP_FIM) && !op_a[0]);
    endfunction

endpackage

// File: rtl/pc_sequencer_cycle_counter.sv
// Free-running 3-bit instruction-step counter with hold and synchronous clear;
// at_boundary marks the last step (X3) of an instruction cycle.
module seq_cycle_counter
    import pc_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       hold,
    output logic [2:0] cycle,
    output logic       at_boundary
);

    always_ff @(posedge clock) begin
        if (!reset_n)
            cycle <= CYC_A1;
        else if (!hold)
            cycle <= cycle + 3'd1;
    end

    assign at_boundary = (cycle == CYC_X3);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-cycle sequencer: opcode latching, PC-stack strobes, halt handshake
// and call-depth tracking. Define PC_SEQ_JIN_EN to decode JIN (OPR 0x3, odd OPA).
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] data,
    input  logic       cond_true,
    input  logic       halt_req,
    output logic       halt_ack,
    output logic [2:0] cycle,
    output logic       pc_halt,
    output logic [1:0] stack_control,
    output logic [2:0] pc_write_enable,
    output logic [1:0] pc_next_sel,
    output logic [3:0] inst_operand,
    output logic [3:0] reg_addr,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic       second_word,
    output logic       stack_ovf
);

    logic       halted;
    logic       pend_pop;
    logic       taken;
    logic       at_boundary;
    logic [1:0] depth;
    logic [3:0] w2_opr;
    logic [3:0] w2_opa;
    logic       next_two;
    logic       next_bbl;
    logic       halt_ok;
    logic       is_jump;
    logic       is_cond;
    stack_ctl_e stk;
    next_sel_e  sel;

    seq_cycle_counter u_cycle_counter (
        .clock       (clock),
        .reset_n     (reset_n),
        .hold        (halted),
        .cycle       (cycle),
        .at_boundary (at_boundary)
    );

    // Flags the boundary will raise; a halt is only taken once the whole
    // instruction (second word or BBL dummy cycle) has completed.
    assign next_two = !second_word && !pend_pop && is_two_word(opr, opa);
    assign next_bbl = !second_word && !pend_pop && (opr == OP_BBL);
    assign halt_ok  = halt_req && !next_two && !next_bbl;
    assign is_jump  = (opr == OP_JUN) || (opr == OP_JMS);
    assign is_cond  = (opr == OP_JCN) || (opr == OP_ISZ);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            halted      <= 1'b0;
            second_word <= 1'b0;
            pend_pop    <= 1'b0;
            taken       <= 1'b0;
            depth       <= 2'd0;
            stack_ovf   <= 1'b0;
        end else begin
            if (halted) begin
                if (!halt_req)
                    halted <= 1'b0;
            end else if (at_boundary) begin
                second_word <= next_two;
                pend_pop    <= next_bbl;
                halted      <= halt_ok;
            end
            if (second_word && (cycle == CYC_M2))
                taken <= cond_true;
            if (stk == STK_PUSH) begin
                if (depth == 2'd3)
                    stack_ovf <= 1'b1;
                else
                    depth <= depth + 2'd1;
            end else if ((stk == STK_POP) && (depth != 2'd0)) begin
                depth <= depth - 2'd1;
            end
        end
    end

    // The BBL dummy cycle fetches nothing.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            opr    <= 4'h0;
            opa    <= 4'h0;
            w2_opr <= 4'h0;
            w2_opa <= 4'h0;
        end else if (!pend_pop) begin
            if (cycle == CYC_M1) begin
                if (second_word)
                    w2_opr <= data;
                else
                    opr <= data;
            end
            if (cycle == CYC_M2) begin
                if (second_word)
                    w2_opa <= data;
                else
                    opa <= data;
            end
        end
    end

    always_comb begin
        stk             = STK_NOP;
        sel             = SEL_INST;
        pc_write_enable = 3'b000;
        inst_operand    = 4'h0;
        reg_addr        = 4'h0;
        if (pend_pop) begin
            if (cycle == CYC_A3)
                stk = STK_POP;
        end else if (second_word) begin
            if ((opr == OP_JMS) && (cycle == CYC_A3))
                stk = STK_PUSH;
            // Conditional jumps stay within the current page: no X3 write.
            if (is_jump || (is_cond && taken)) begin
                if (cycle == CYC_X1) begin
                    pc_write_enable = 3'b001;
                    inst_operand    = w2_opa;
                end else if (cycle == CYC_X2) begin
                    pc_write_enable = 3'b010;
                    inst_operand    = w2_opr;
                end else if ((cycle == CYC_X3) && is_jump) begin
                    pc_write_enable = 3'b100;
                    inst_operand    = opa;
                end
            end
        end
`ifdef PC_SEQ_JIN_EN
        else if ((opr == OP_JIN) && opa[0]) begin
            if (cycle == CYC_X1) begin
                sel             = SEL_REG;
                reg_addr        = {opa[3:1], 1'b1};
                pc_write_enable = 3'b001;
            end else if (cycle == CYC_X2) begin
                sel             = SEL_REG;
                reg_addr        = {opa[3:1], 1'b0};
                pc_write_enable = 3'b010;
            end
        end
`endif
    end

    assign stack_control = stk;
    assign pc_next_sel   = sel;
    assign pc_halt       = halted;
    assign halt_ack      = halted;

endmodule
